// File: rtl/multiplier_if.sv
// -----------------------------------------------------------------------------
// multiplier_if
//   Execute-stage <-> multiply unit handshake bundle.
//   master (stage owner) : drives instr, a_in, b_in, flush; receives valid, c_out
//   slave  (multiplier)  : receives instr, a_in, b_in, flush; drives valid, c_out
//   instr  : decoded instruction fields used by the unit (funct7, funct3)
//   a_in   : rs1 operand, b_in : rs2 operand (32 bit)
//   flush  : synchronous pipeline kill
//   valid  : one-cycle result pulse, c_out : registered result
// -----------------------------------------------------------------------------
interface multiplier_if;
  typedef struct packed {
    logic [6:0] funct7;
    logic [2:0] funct3;
  } instr_t;

  instr_t      instr;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        flush;
  logic        valid;
  logic [31:0] c_out;

  modport master (output instr, a_in, b_in, flush, input valid, c_out);
  modport slave  (input instr, a_in, b_in, flush, output valid, c_out);
endinterface

// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//   Iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU). Multiplies operand
//   magnitudes by shift-add, BITS_PER_CYCLE multiplier bits per cycle, then
//   re-applies the sign. Fixed latency: start in cycle 0 -> valid in cycle N+1.
//   clk : clock, all state on posedge
//   rst : asynchronous active-high reset
//   bus : multiplier_if slave (instr, a_in, b_in, flush in; valid, c_out out)
//
//   state | meaning
//   IDLE  | waiting for an M-extension multiply instruction
//   CALC  | accumulating partial products, N cycles
//   DONE  | result in c_out, valid high for this single cycle
// -----------------------------------------------------------------------------
module multiplier #(
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  multiplier_if.slave bus
);
  localparam int B  = BITS_PER_CYCLE;
  localparam int N  = 32 / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [6:0] M_INSTR   = 7'b0000001;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q;
  logic [CW-1:0] count_q;
  logic [63:0] acc_q;
  logic [31:0] mag_a_q;
  logic [31:0] mag_b_q;
  logic [31:0] c_out_q;
  logic [2:0]  funct3_q;
  logic        neg_q;

  logic        start;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic [B-1:0] digit;
  logic [63:0] acc_d;
  logic [63:0] prod;

  always_comb begin
    start   = (bus.instr.funct7 == M_INSTR) && !bus.instr.funct3[2];
    sign_a  = bus.a_in[31] & ((bus.instr.funct3 == F3_MULH) || (bus.instr.funct3 == F3_MULHSU));
    sign_b  = bus.b_in[31] & (bus.instr.funct3 == F3_MULH);
    // 0x8000_0000 negates to itself, which is still the right unsigned magnitude
    mag_a_d = sign_a ? (~bus.a_in + 32'd1) : bus.a_in;
    mag_b_d = sign_b ? (~bus.b_in + 32'd1) : bus.b_in;
    digit   = mag_b_q[count_q*B +: B];
    acc_d   = acc_q + ((64'(mag_a_q) * 64'(digit)) << (count_q*B));
    // sign applied to the accumulator value that is being written this edge,
    // so c_out can load on the last CALC edge
    prod    = neg_q ? (~acc_d + 64'd1) : acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      acc_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      c_out_q  <= '0;
      funct3_q <= '0;
      neg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.flush && start) begin
            funct3_q <= bus.instr.funct3;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= sign_a ^ sign_b;
            acc_q    <= '0;
            count_q  <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= acc_d;
            count_q <= count_q + CW'(1);
            if (count_q == CW'(N - 1)) begin
              state_q <= DONE;
              c_out_q <= (funct3_q == F3_MUL) ? prod[31:0] : prod[63:32];
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.valid = (state_q == DONE);
  assign bus.c_out = c_out_q;
endmodule

// File: tb/tb_multiplier.sv
module tb_multiplier;
  localparam int BPC = 4;
  localparam int N   = 32 / BPC;
  localparam logic [6:0] M_INSTR = 7'b0000001;
  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   vcyc  = 0;
  logic [31:0] last_c = 32'd0;

  multiplier_if mif();
  multiplier #(.BITS_PER_CYCLE(BPC)) dut (.clk(clk), .rst(rst), .bus(mif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: sign/zero-extend to 64 bits and take the plain product.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = (f3 == MULH || f3 == MULHSU) ? {{32{a[31]}}, a} : {32'd0, a};
    eb = (f3 == MULH) ? {{32{b[31]}}, b} : {32'd0, b};
    p  = ea * eb;
    return (f3 == MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Issues one multiply, checks every cycle up to the
  // valid pulse and the IDLE bubble after it; returns at the bubble negedge.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string tag);
    mif.instr = {M_INSTR, f3};
    mif.a_in  = a;
    mif.b_in  = b;
    mif.flush = 1'b0;
    @(posedge clk);
    #1;
    mif.instr = {7'h00, 3'($urandom)};
    mif.a_in  = $urandom;
    mif.b_in  = $urandom;
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 32'(mif.valid), 32'(c == N + 1));
      if (c == N + 1) begin
        chk({tag, "_c_out"}, mif.c_out, exp);
        last_c = exp;
        vcyc   = cyc;
      end else begin
        chk({tag, "_hold"}, mif.c_out, last_c);
      end
    end
    @(negedge clk);
    chk({tag, "_pulse_end"}, 32'(mif.valid), 32'd0);
  endtask

  initial begin
    int t1, t2;
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    logic [31:0] corner [6];
    corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_FFFF};

    rst = 1'b1;
    mif.instr = '0;
    mif.a_in  = '0;
    mif.b_in  = '0;
    mif.flush = 1'b0;
    #1;
    chk("reset_valid", 32'(mif.valid), 32'd0);
    chk("reset_c_out", mif.c_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_op(MUL,    32'd7,         32'd6,         32'h0000_002A, "mul_7x6");
    run_op(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    run_op(MUL,    32'h8000_0000, 32'h8000_0000, 32'h0000_0000, "mul_min");
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ones");
    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ones");
    run_op(MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, "mulh_m3x5");
    run_op(MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, "mul_m3x5");
    run_op(MULH,   32'h0,         32'h8000_0000, 32'h0,         "mulh_zero");

    // flush during CALC: no result, then a fresh op runs at full latency
    mif.instr = {M_INSTR, MUL};
    mif.a_in  = 32'd100;
    mif.b_in  = 32'd3;
    @(posedge clk);
    #1;
    mif.instr = '0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("flush_pre_valid", 32'(mif.valid), 32'd0);
    end
    mif.flush = 1'b1;
    @(posedge clk);
    #1;
    mif.flush = 1'b0;
    @(negedge clk);
    chk("flush_valid", 32'(mif.valid), 32'd0);
    chk("flush_c_out", mif.c_out, last_c);
    run_op(MUL, 32'd9, 32'd9, 32'd81, "after_flush");

    // back-to-back: second valid N+2 cycles after the first
    run_op(MULHU, 32'h1234_5678, 32'h9ABC_DEF0, model(MULHU, 32'h1234_5678, 32'h9ABC_DEF0), "b2b_1");
    t1 = vcyc;
    run_op(MULH, 32'hDEAD_BEEF, 32'h0BAD_F00D, model(MULH, 32'hDEAD_BEEF, 32'h0BAD_F00D), "b2b_2");
    t2 = vcyc;
    chk("b2b_spacing", 32'(t2 - t1), 32'(N + 2));

    // async reset in the middle of CALC clears c_out at once
    mif.instr = {M_INSTR, MUL};
    mif.a_in  = 32'h1234;
    mif.b_in  = 32'h5678;
    @(posedge clk);
    #1;
    mif.instr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(mif.valid), 32'd0);
    chk("rst_mid_c_out", mif.c_out, 32'd0);
    last_c = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("rst_after_valid", 32'(mif.valid), 32'd0);
    end

    run_op(MUL, 32'd11, 32'd13, 32'd143, "post_rst");

    // DIV held for 20 cycles, then a non-M instruction: never leaves IDLE
    mif.instr = {M_INSTR, 3'b100};
    mif.a_in  = 32'd50;
    mif.b_in  = 32'd5;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("div_valid", 32'(mif.valid), 32'd0);
      chk("div_c_out", mif.c_out, last_c);
    end
    mif.instr = {7'h00, MUL};
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("nonm_valid", 32'(mif.valid), 32'd0);
    end
    mif.instr = '0;
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      rf = 3'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      run_op(rf, ra, rb, model(rf, ra, rb), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
